// File: rtl/alu_defs.sv
// Opcode constants of the shared combinational arith unit.
package alu_defs;

  localparam logic [2:0] MOV_      = 3'd0;
  localparam logic [2:0] ARITH_ADD = 3'd1;
  localparam logic [2:0] ARITH_MOD = 3'd3;

endpackage

// File: rtl/modexp_seq_pkg.sv
// State and return-target types shared by modexp_seq and modmul_seq.
package modexp_defs;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_INIT_B,
    ST_INIT_R,
    ST_SKIP,
    ST_SQ_LOAD,
    ST_MUL_LOAD,
    ST_MM_WAIT,
    ST_EXP_STEP,
    ST_DONE
  } exp_state_t;

  typedef enum logic [2:0] {
    MM_IDLE,
    MM_DBL,
    MM_DBL_MOD,
    MM_ADD,
    MM_ADD_MOD,
    MM_STEP
  } mm_state_t;

  typedef enum logic {
    RET_SQ,
    RET_MUL
  } ret_t;

endpackage

// File: rtl/modexp_seq_modmul.sv
// Shift-and-add modular multiply (x * y mod modulus) built from ADD and MOD steps on the arith unit.
// Inputs are latched on start; done pulses the cycle after the last step, with the product on acc.
module modmul_seq
  import alu_defs::*;
  import modexp_defs::*;
#(
  parameter int N = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [N-1:0] x,
  input  logic [N-1:0] y,
  input  logic [N-1:0] modulus,
  input  logic [N-1:0] alu_result,
  output logic         done,
  output logic [N-1:0] acc,
  output logic [N-1:0] alu_a,
  output logic [N-1:0] alu_b,
  output logic [2:0]   alu_opcode
);

  localparam int J_W = $clog2(N);

  mm_state_t      state;
  logic [N-1:0]   x_reg;
  logic [N-1:0]   y_reg;
  logic [J_W-1:0] j;

  always_comb begin
    alu_opcode = MOV_;
    alu_a      = '0;
    alu_b      = '0;
    case (state)
      MM_DBL: begin
        alu_opcode = ARITH_ADD;
        alu_a      = acc;
        alu_b      = acc;
      end
      MM_ADD: begin
        alu_opcode = ARITH_ADD;
        alu_a      = acc;
        alu_b      = x_reg;
      end
      MM_DBL_MOD, MM_ADD_MOD: begin
        alu_opcode = ARITH_MOD;
        alu_a      = acc;
        alu_b      = modulus;
      end
      default: ;
    endcase
  end

  // acc stays below modulus < 2^(N-1), so acc+acc and acc+x never overflow N bits
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= MM_IDLE;
      x_reg <= '0;
      y_reg <= '0;
      acc   <= '0;
      j     <= '0;
      done  <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        MM_IDLE: begin
          if (start) begin
            x_reg <= x;
            y_reg <= y;
            acc   <= '0;
            j     <= J_W'(N - 1);
            state <= MM_DBL;
          end
        end
        MM_DBL: begin
          acc   <= alu_result;
          state <= MM_DBL_MOD;
        end
        MM_DBL_MOD: begin
          acc   <= alu_result;
          state <= y_reg[j] ? MM_ADD : MM_STEP;
        end
        MM_ADD: begin
          acc   <= alu_result;
          state <= MM_ADD_MOD;
        end
        MM_ADD_MOD: begin
          acc   <= alu_result;
          state <= MM_STEP;
        end
        MM_STEP: begin
          if (j == '0) begin
            done  <= 1'b1;
            state <= MM_IDLE;
          end else begin
            j     <= j - J_W'(1);
            state <= MM_DBL;
          end
        end
        default: state <= MM_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/modexp_seq.sv
// Modular exponentiation sequencer: base^exp mod n by left-to-right square-and-multiply on the arith unit.
// Optional build macro MODEXP_SKIP_LZ_EN skips leading zero exponent bits (1 cycle each) before squaring.
module modexp_seq
  import alu_defs::*;
  import modexp_defs::*;
#(
  parameter int N = 8
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         start_i,
  input  logic [N-1:0] base_i,
  input  logic [N-1:0] exp_i,
  input  logic [N-1:0] mod_i,
  output logic         busy_o,
  output logic         done_o,
  output logic         error_o,
  output logic [N-1:0] result_o,
  output logic [N-1:0] alu_a_o,
  output logic [N-1:0] alu_b_o,
  output logic [2:0]   alu_opcode_o,
  input  logic [N-1:0] alu_result_i
);

  localparam int K_W = $clog2(N);

  exp_state_t     state;
  ret_t           ret;
  logic [N-1:0]   base_reg;
  logic [N-1:0]   exp_reg;
  logic [N-1:0]   n_reg;
  logic [N-1:0]   b_reg;
  logic [N-1:0]   r_reg;
  logic [K_W-1:0] k;

  logic           mm_start;
  logic           mm_done;
  logic [N-1:0]   mm_y;
  logic [N-1:0]   mm_acc;
  logic [N-1:0]   mm_alu_a;
  logic [N-1:0]   mm_alu_b;
  logic [2:0]     mm_alu_opcode;

  // ST_SKIP doubles as the square load once it reaches the leading one
  assign mm_start = (state == ST_SQ_LOAD) || (state == ST_MUL_LOAD) ||
                    ((state == ST_SKIP) && exp_reg[k]);
  assign mm_y     = (state == ST_MUL_LOAD) ? b_reg : r_reg;

  modmul_seq #(.N(N)) u_modmul (
    .clk        (clk_i),
    .rst        (rst_i),
    .start      (mm_start),
    .x          (r_reg),
    .y          (mm_y),
    .modulus    (n_reg),
    .alu_result (alu_result_i),
    .done       (mm_done),
    .acc        (mm_acc),
    .alu_a      (mm_alu_a),
    .alu_b      (mm_alu_b),
    .alu_opcode (mm_alu_opcode)
  );

  always_comb begin
    alu_opcode_o = MOV_;
    alu_a_o      = '0;
    alu_b_o      = '0;
    case (state)
      ST_INIT_B: begin
        alu_opcode_o = ARITH_MOD;
        alu_a_o      = base_reg;
        alu_b_o      = n_reg;
      end
      ST_INIT_R: begin
        alu_opcode_o = ARITH_MOD;
        alu_a_o      = N'(1);
        alu_b_o      = n_reg;
      end
      ST_MM_WAIT: begin
        alu_opcode_o = mm_alu_opcode;
        alu_a_o      = mm_alu_a;
        alu_b_o      = mm_alu_b;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state    <= ST_IDLE;
      ret      <= RET_SQ;
      base_reg <= '0;
      exp_reg  <= '0;
      n_reg    <= '0;
      b_reg    <= '0;
      r_reg    <= '0;
      k        <= '0;
      busy_o   <= 1'b0;
      done_o   <= 1'b0;
      error_o  <= 1'b0;
      result_o <= '0;
    end else begin
      done_o <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start_i) begin
            base_reg <= base_i;
            exp_reg  <= exp_i;
            n_reg    <= mod_i;
            k        <= K_W'(N - 1);
            busy_o   <= 1'b1;
            if (mod_i == '0 || mod_i[N-1]) begin
              error_o  <= 1'b1;
              result_o <= '0;
              done_o   <= 1'b1;
              state    <= ST_DONE;
            end else begin
              error_o <= 1'b0;
              state   <= ST_INIT_B;
            end
          end
        end
        ST_INIT_B: begin
          b_reg <= alu_result_i;
          state <= ST_INIT_R;
        end
        ST_INIT_R: begin
          r_reg <= alu_result_i;
`ifdef MODEXP_SKIP_LZ_EN
          state <= ST_SKIP;
`else
          state <= ST_SQ_LOAD;
`endif
        end
        ST_SKIP: begin
          if (exp_reg[k]) begin
            ret   <= RET_SQ;
            state <= ST_MM_WAIT;
          end else if (k == '0) begin
            result_o <= r_reg;
            done_o   <= 1'b1;
            state    <= ST_DONE;
          end else begin
            k <= k - K_W'(1);
          end
        end
        ST_SQ_LOAD: begin
          ret   <= RET_SQ;
          state <= ST_MM_WAIT;
        end
        ST_MUL_LOAD: begin
          ret   <= RET_MUL;
          state <= ST_MM_WAIT;
        end
        ST_MM_WAIT: begin
          if (mm_done) begin
            r_reg <= mm_acc;
            state <= (ret == RET_SQ && exp_reg[k]) ? ST_MUL_LOAD : ST_EXP_STEP;
          end
        end
        ST_EXP_STEP: begin
          if (k == '0) begin
            result_o <= r_reg;
            done_o   <= 1'b1;
            state    <= ST_DONE;
          end else begin
            k     <= k - K_W'(1);
            state <= ST_SQ_LOAD;
          end
        end
        ST_DONE: begin
          busy_o <= 1'b0;
          state  <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_modexp_seq.sv
// Scoreboard bench for modexp_seq: driver pushes expected result/error/latency, monitor checks on done_o.
module tb_modexp_seq;
  import alu_defs::*;

  localparam int N = 8;

  logic         clk_i = 1'b0;
  logic         rst_i;
  logic         start_i;
  logic [N-1:0] base_i, exp_i, mod_i;
  logic         busy_o, done_o, error_o;
  logic [N-1:0] result_o, alu_a_o, alu_b_o, alu_result_i;
  logic [2:0]   alu_opcode_o;

  modexp_seq #(.N(N)) dut (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .start_i      (start_i),
    .base_i       (base_i),
    .exp_i        (exp_i),
    .mod_i        (mod_i),
    .busy_o       (busy_o),
    .done_o       (done_o),
    .error_o      (error_o),
    .result_o     (result_o),
    .alu_a_o      (alu_a_o),
    .alu_b_o      (alu_b_o),
    .alu_opcode_o (alu_opcode_o),
    .alu_result_i (alu_result_i)
  );

  always #5 clk_i = ~clk_i;

  // behavioural arith unit
  always_comb begin
    case (alu_opcode_o)
      ARITH_ADD: alu_result_i = alu_a_o + alu_b_o;
      ARITH_MOD: alu_result_i = (alu_b_o == '0) ? '0 : alu_a_o % alu_b_o;
      default:   alu_result_i = alu_a_o;
    endcase
  end

  int cyc = 0;
  always @(posedge clk_i) cyc++;

  typedef struct {
    logic [N-1:0] res;
    logic         err;
    int           lat;
    int           s;
  } exp_t;

  exp_t sb_q[$];
  exp_t mon_e;
  int   checks   = 0;
  int   failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  // cycles from the start_i cycle through the done_o cycle inclusive
  function automatic int model_lat(input int b, input int e, input int n);
    int r, bb, lat;
`ifdef MODEXP_SKIP_LZ_EN
    bit lead = 1'b1;
`endif
    r   = 1 % n;
    bb  = b % n;
    lat = 4 + N;
    for (int kk = N - 1; kk >= 0; kk--) begin
`ifdef MODEXP_SKIP_LZ_EN
      if (lead && !e[kk]) continue;
      lead = 1'b0;
`endif
      lat += 2 + 3 * N + 2 * $countones(r);
      r = (r * r) % n;
      if (e[kk]) begin
        lat += 2 + 3 * N + 2 * $countones(bb);
        r = (r * bb) % n;
      end
    end
    return lat;
  endfunction

  always @(negedge clk_i) begin
    if (!rst_i && done_o) begin
      if (sb_q.size() == 0) begin
        check("spurious_done", 32'd1, 32'd0);
      end else begin
        mon_e = sb_q.pop_front();
        check("result", result_o, mon_e.res);
        check("error", error_o, mon_e.err);
        check("latency", cyc - mon_e.s + 1, mon_e.lat);
        check("busy_at_done", busy_o, 32'd1);
      end
    end
  end

  task automatic wait_drain(input string name);
    int t = 0;
    while (sb_q.size() != 0 && t < 3000) begin
      @(negedge clk_i);
      t++;
    end
    if (sb_q.size() != 0) begin
      check({name, "_timeout"}, 32'd0, 32'd1);
      sb_q.delete();
    end
    repeat (3) @(negedge clk_i);
  endtask

  task automatic issue(input logic [N-1:0] b, input logic [N-1:0] e, input logic [N-1:0] n,
                       input logic [N-1:0] res, input logic err);
    exp_t x;
    @(negedge clk_i);
    base_i  = b;
    exp_i   = e;
    mod_i   = n;
    start_i = 1'b1;
    x.res = res;
    x.err = err;
    x.lat = err ? 2 : model_lat(int'(b), int'(e), int'(n));
    x.s   = cyc;
    sb_q.push_back(x);
    @(negedge clk_i);
    start_i = 1'b0;
    check("busy_after_start", busy_o, 32'd1);
  endtask

  task automatic run(input logic [N-1:0] b, input logic [N-1:0] e, input logic [N-1:0] n,
                     input logic [N-1:0] res, input logic err, input string name);
    issue(b, e, n, res, err);
    wait_drain(name);
  endtask

  task automatic check_outputs_zero(input string name);
    check({name, "_busy"}, busy_o, 32'd0);
    check({name, "_done"}, done_o, 32'd0);
    check({name, "_error"}, error_o, 32'd0);
    check({name, "_result"}, result_o, 32'd0);
    check({name, "_opcode"}, alu_opcode_o, 32'(MOV_));
    check({name, "_alu_a"}, alu_a_o, 32'd0);
    check({name, "_alu_b"}, alu_b_o, 32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_i   = 1'b1;
    start_i = 1'b0;
    base_i  = '0;
    exp_i   = '0;
    mod_i   = '0;
    repeat (3) @(negedge clk_i);
    check_outputs_zero("reset");
    rst_i = 1'b0;

    run(8'd4,   8'd13, 8'd97,  8'd93,  1'b0, "main");
    run(8'd200, 8'd2,  8'd97,  8'd36,  1'b0, "base_reduce");
    run(8'd5,   8'd0,  8'd97,  8'd1,   1'b0, "exp_zero");
    run(8'd5,   8'd3,  8'd1,   8'd0,   1'b0, "mod_one");
    run(8'd5,   8'd3,  8'd0,   8'd0,   1'b1, "mod_zero");
    run(8'd5,   8'd3,  8'd200, 8'd0,   1'b1, "mod_msb");
    run(8'd3,   8'd5,  8'd128, 8'd0,   1'b1, "mod_128");
    run(8'd3,   8'd5,  8'd127, 8'd116, 1'b0, "mod_max");
    run(8'd97,  8'd5,  8'd97,  8'd0,   1'b0, "base_eq_n");
    run(8'd2,   8'd255, 8'd11, 8'd10,  1'b0, "exp_all_ones");

    // second start while busy must be ignored
    issue(8'd4, 8'd13, 8'd97, 8'd93, 1'b0);
    repeat (30) @(negedge clk_i);
    base_i  = 8'd9;
    exp_i   = 8'd7;
    mod_i   = 8'd11;
    start_i = 1'b1;
    @(negedge clk_i);
    start_i = 1'b0;
    wait_drain("mid_start");
    check("result_hold", result_o, 32'd93);

    // reset 20 cycles into a run aborts it with no done_o
    @(negedge clk_i);
    base_i  = 8'd4;
    exp_i   = 8'd13;
    mod_i   = 8'd97;
    start_i = 1'b1;
    @(negedge clk_i);
    start_i = 1'b0;
    repeat (19) @(negedge clk_i);
    rst_i = 1'b1;
    @(negedge clk_i);
    rst_i = 1'b0;
    check_outputs_zero("abort");
    repeat (600) @(negedge clk_i);
    check("abort_idle", busy_o, 32'd0);

    run(8'd4, 8'd13, 8'd97, 8'd93, 1'b0, "after_abort");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
